// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_wr_arbiter: round-robin arbiter funnelling N_REQ writers into a FIFO |
// | Optional blocked-request counter enabled by macro ARB_BLOCK_CNT_EN.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fifo_wr_arbiter #(
  parameter int FIFO_WIDTH = 16,
  parameter int N_REQ      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            ack,
  output logic                        fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]       fifo_data_in,
  input  logic                        fifo_full,
  input  logic                        fifo_wr_ack,
  input  logic                        fifo_overflow,
  output logic                        busy,
  output logic [15:0]                 blk_cnt
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_ISSUE    = 2'd1;
  localparam logic [1:0] c_WAIT_ACK = 2'd2;

  logic [1:0]            r_state;
  logic [IDX_W-1:0]      r_winner;
  logic [IDX_W-1:0]      r_last_gnt;
  logic [FIFO_WIDTH-1:0] r_data;

  logic                  w_found;
  logic [IDX_W-1:0]      w_win;
  logic [IDX_W-1:0]      w_idx;
  logic [FIFO_WIDTH-1:0] w_slice;

  // Round-robin search starting one past the last acknowledged requester.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last_gnt;
    w_idx   = r_last_gnt;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = IDX_W'((int'(r_last_gnt) + k) % N_REQ);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_slice = req_data[w_win*FIFO_WIDTH +: FIFO_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_IDLE;
      r_winner   <= '0;
      r_last_gnt <= IDX_W'(N_REQ - 1);
      r_data     <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_found && !fifo_full) begin
            r_winner <= w_win;
            r_data   <= w_slice;
            r_state  <= c_ISSUE;
          end
        end
        c_ISSUE: begin
          r_state <= c_WAIT_ACK;
        end
        c_WAIT_ACK: begin
          // Overflow leaves last_gnt untouched so the same requester wins again.
          if (fifo_wr_ack) begin
            r_last_gnt <= r_winner;
            r_state    <= c_IDLE;
          end else if (fifo_overflow) begin
            r_state <= c_IDLE;
          end
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign fifo_wr_en   = (r_state == c_ISSUE);
  assign fifo_data_in = r_data;
  assign busy         = (r_state != c_IDLE);

  generate
    for (genvar i = 0; i < N_REQ; i++) begin : g_ack
      assign ack[i] = (r_state == c_WAIT_ACK) && fifo_wr_ack &&
                      (r_winner == IDX_W'(i));
    end
  endgenerate

`ifdef ARB_BLOCK_CNT_EN
  logic [15:0] r_blk_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk_cnt <= 16'h0000;
    end else if ((r_state == c_IDLE) && (|req) && fifo_full &&
                 (r_blk_cnt != 16'hFFFF)) begin
      r_blk_cnt <= r_blk_cnt + 16'd1;
    end
  end

  assign blk_cnt = r_blk_cnt;
`else
  assign blk_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire
